// File: rtl/jump_controller_pkg.sv
// Shared constants and encodings for the jump controller: playfield geometry,
// FSM state encoding and jump direction.
package jump_controller_pkg;

  localparam int JC_NUM_COLS  = 7;
  localparam int JC_START_COL = 3;
  localparam int COL_W        = 3;

  typedef enum logic [1:0] {
    JC_IDLE    = 2'd0,
    JC_FIRE    = 2'd1,
    JC_LOCKOUT = 2'd2
  } jc_state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } jc_dir_e;

endpackage

// File: rtl/jump_controller_if.sv
// Bundle of the jump controller's game-side signals: buttons and control flags
// in, jump pulses and character column out.
interface jump_controller_if;
  import jump_controller_pkg::*;

  logic             one_ms_tick;
  logic             game_en;
  logic             jump_fail;
  logic             btn_left;
  logic             btn_right;
  logic             jump_left;
  logic             jump_right;
  logic             busy;
  logic [COL_W-1:0] col;

  modport master (
    output one_ms_tick, game_en, jump_fail, btn_left, btn_right,
    input  jump_left, jump_right, busy, col
  );

  modport slave (
    input  one_ms_tick, game_en, jump_fail, btn_left, btn_right,
    output jump_left, jump_right, busy, col
  );

endinterface

// File: rtl/jump_controller_debounce.sv
// Per-button front end: 2-FF synchronizer, millisecond-sampled debouncer and
// single-cycle rising-edge detect on the accepted level.
module button_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic one_ms_tick,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A differing level must persist for DEBOUNCE_MS consecutive ticks; any
  // tick that sees the stable level again restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (one_ms_tick) begin
      if (sync_q[1] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
        stable_d = sync_q[1];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= {sync_q[0], btn_raw};
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = stable_q & ~stable_dly_q;

endmodule

// File: rtl/jump_controller.sv
// Turns debounced left/right presses into registered one-cycle jump pulses,
// tracks the character column and locks out presses during the shift animation.
module jump_controller
  import jump_controller_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LOCKOUT_MS  = 250,
  parameter int NUM_COLS    = JC_NUM_COLS,
  parameter int START_COL   = JC_START_COL
) (
  input logic               clk,
  input logic               rst,
  jump_controller_if.slave  bus
);

  localparam int LCK_W = $clog2(LOCKOUT_MS + 1);

  logic lvl_l, rise_l, lvl_r, rise_r;

  jc_state_e        state_q, state_d;
  jc_dir_e          dir_q, dir_d;
  logic [LCK_W-1:0] lck_q, lck_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             jl_q, jl_d, jr_q, jr_d;
  logic             run;
  logic             can_left, can_right;

  button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_left (
    .clk         (clk),
    .rst         (rst),
    .one_ms_tick (bus.one_ms_tick),
    .btn_raw     (bus.btn_left),
    .level       (lvl_l),
    .rise        (rise_l)
  );

  button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_right (
    .clk         (clk),
    .rst         (rst),
    .one_ms_tick (bus.one_ms_tick),
    .btn_raw     (bus.btn_right),
    .level       (lvl_r),
    .rise        (rise_r)
  );

  assign run = bus.game_en & ~bus.jump_fail;

  // A press only counts while the other button is stably released; a
  // simultaneous rise sets the other level too, so it is rejected as well.
  assign can_left  = rise_l & ~lvl_r & ~rise_r & (col_q != '0);
  assign can_right = rise_r & ~lvl_l & ~rise_l & (col_q != COL_W'(NUM_COLS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= JC_IDLE;
      dir_q   <= DIR_LEFT;
      lck_q   <= '0;
      col_q   <= COL_W'(START_COL);
      jl_q    <= 1'b0;
      jr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      lck_q   <= lck_d;
      col_q   <= col_d;
      jl_q    <= jl_d;
      jr_q    <= jr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lck_d   = lck_q;
    if (!run) begin
      state_d = JC_IDLE;
      lck_d   = '0;
    end else begin
      case (state_q)
        JC_IDLE: begin
          if (can_left) begin
            dir_d   = DIR_LEFT;
            state_d = JC_FIRE;
          end else if (can_right) begin
            dir_d   = DIR_RIGHT;
            state_d = JC_FIRE;
          end
        end
        JC_FIRE: begin
          lck_d   = '0;
          state_d = JC_LOCKOUT;
        end
        JC_LOCKOUT: begin
          if (bus.one_ms_tick) begin
            if (lck_q == LCK_W'(LOCKOUT_MS - 1)) begin
              lck_d   = '0;
              state_d = JC_IDLE;
            end else begin
              lck_d = lck_q + 1'b1;
            end
          end
        end
        default: state_d = JC_IDLE;
      endcase
    end
  end

  // Pulse and column move are computed from FIRE and registered together.
  always_comb begin
    jl_d  = (state_q == JC_FIRE) && (dir_q == DIR_LEFT)  && run;
    jr_d  = (state_q == JC_FIRE) && (dir_q == DIR_RIGHT) && run;
    col_d = col_q;
    if (!bus.game_en) begin
      col_d = COL_W'(START_COL);
    end else if (jl_d) begin
      col_d = col_q - 1'b1;
    end else if (jr_d) begin
      col_d = col_q + 1'b1;
    end
  end

  assign bus.jump_left  = jl_q;
  assign bus.jump_right = jr_q;
  assign bus.busy       = (state_q != JC_IDLE);
  assign bus.col        = col_q;

endmodule

// File: tb/tb_jump_controller.sv
// Bench for jump_controller: millisecond-granular reference model of presses,
// debounce, lockout and column, driven by directed and random button sequences.
module tb_jump_controller;

  localparam int DB   = 3;
  localparam int LK   = 5;
  localparam int NCOL = 7;
  localparam int SCOL = 3;

  logic clk = 1'b0;
  logic rst;

  jump_controller_if bus ();

  jump_controller #(
    .DEBOUNCE_MS (DB),
    .LOCKOUT_MS  (LK),
    .NUM_COLS    (NCOL),
    .START_COL   (SCOL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state, advanced once per millisecond window.
  int   k = 0;
  int   m_stable [2];
  int   m_cnt    [2];
  int   m_col;
  int   m_lock;
  logic m_bl, m_br;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_stable[b] = 0;
      m_cnt[b]    = 0;
    end
    m_col  = SCOL;
    m_lock = k;
  endtask

  // One millisecond tick: a new level held DB ticks in a row is accepted; a
  // jump then blocks presses accepted during the following LK-1 ticks.
  task automatic model_tick(input logic raw_l, input logic raw_r, input logic en,
                            input logic fail, output int el, output int er);
    int rise [2];
    int raw;
    for (int b = 0; b < 2; b++) begin
      raw     = (b == 0) ? int'(raw_l) : int'(raw_r);
      rise[b] = 0;
      if (raw == m_stable[b]) begin
        m_cnt[b] = 0;
      end else begin
        m_cnt[b]++;
        if (m_cnt[b] == DB) begin
          m_stable[b] = raw;
          m_cnt[b]    = 0;
          rise[b]     = raw;
        end
      end
    end
    el = 0;
    er = 0;
    if (!en) begin
      m_col  = SCOL;
      m_lock = k;
    end else if (fail) begin
      m_lock = k;
    end else if (k >= m_lock) begin
      if (rise[0] == 1 && m_stable[1] == 0 && m_col > 0) begin
        el = 1;
        m_col--;
        m_lock = k + LK;
      end else if (rise[1] == 1 && m_stable[0] == 0 && m_col < NCOL - 1) begin
        er = 1;
        m_col++;
        m_lock = k + LK;
      end
    end
  endtask

  // One 10-clock millisecond: tick on the first clock, buttons changed on the
  // third, outputs sampled on every falling edge.
  task automatic step(input logic bl, input logic br, input logic en, input logic fail,
                      input string tag);
    int   el, er, nl, nr;
    logic exp_busy;
    model_tick(m_bl, m_br, en, fail, el, er);
    exp_busy      = (k < m_lock);
    bus.game_en   = en;
    bus.jump_fail = fail;
    nl = 0;
    nr = 0;
    for (int c = 0; c < 10; c++) begin
      bus.one_ms_tick = (c == 0);
      if (c == 2) begin
        bus.btn_left  = bl;
        bus.btn_right = br;
      end
      @(negedge clk);
      nl += int'(bus.jump_left);
      nr += int'(bus.jump_right);
    end
    m_bl = bl;
    m_br = br;
    check($sformatf("%s_k%0d_left_pulses", tag, k), 32'(nl), 32'(el));
    check($sformatf("%s_k%0d_right_pulses", tag, k), 32'(nr), 32'(er));
    check($sformatf("%s_k%0d_col", tag, k), 32'(bus.col), 32'(m_col));
    check($sformatf("%s_k%0d_busy", tag, k), 32'(bus.busy), 32'(exp_busy));
    k++;
  endtask

  task automatic do_reset(input string tag);
    bus.one_ms_tick = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check({tag, "_jump_left"}, 32'(bus.jump_left), 32'd0);
    check({tag, "_jump_right"}, 32'(bus.jump_right), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_col"}, 32'(bus.col), 32'(SCOL));
    model_reset();
  endtask

  task automatic steps(input int n, input logic bl, input logic br, input logic en,
                       input logic fail, input string tag);
    for (int i = 0; i < n; i++) step(bl, br, en, fail, tag);
  endtask

  initial begin
    rst             = 1'b1;
    bus.one_ms_tick = 1'b0;
    bus.game_en     = 1'b0;
    bus.jump_fail   = 1'b0;
    bus.btn_left    = 1'b0;
    bus.btn_right   = 1'b0;
    m_bl            = 1'b0;
    m_br            = 1'b0;
    repeat (3) @(negedge clk);
    do_reset("reset");

    steps(2, 0, 0, 0, 0, "disabled");

    steps(2, 1, 0, 1, 0, "glitch");
    steps(4, 0, 0, 1, 0, "glitch");
    check("col_after_glitch", 32'(bus.col), 32'd3);

    steps(6, 0, 1, 1, 0, "hold_right");
    steps(6, 0, 0, 1, 0, "hold_right");
    check("col_after_right", 32'(bus.col), 32'd4);

    steps(3, 0, 1, 1, 0, "repress");
    steps(3, 0, 0, 1, 0, "repress");
    steps(3, 0, 1, 1, 0, "repress");
    steps(6, 0, 0, 1, 0, "repress");
    check("col_after_repress", 32'(bus.col), 32'd6);

    do_reset("reset2");
    steps(3, 0, 1, 1, 0, "lock_left");
    steps(8, 1, 0, 1, 0, "lock_left");
    steps(4, 0, 0, 1, 0, "lock_left");
    check("col_after_discard", 32'(bus.col), 32'd4);
    steps(4, 1, 0, 1, 0, "lock_left");
    steps(6, 0, 0, 1, 0, "lock_left");
    check("col_after_left", 32'(bus.col), 32'd3);

    steps(4, 1, 1, 1, 0, "both");
    steps(4, 1, 0, 1, 0, "both");
    steps(4, 0, 0, 1, 0, "both");
    check("col_after_both", 32'(bus.col), 32'd3);
    steps(4, 1, 0, 1, 0, "both");
    steps(6, 0, 0, 1, 0, "both");

    for (int i = 0; i < 4; i++) begin
      steps(3, 1, 0, 1, 0, "to_left_edge");
      steps(3, 0, 0, 1, 0, "to_left_edge");
    end
    check("col_left_edge", 32'(bus.col), 32'd0);
    for (int i = 0; i < 8; i++) begin
      steps(3, 0, 1, 1, 0, "to_right_edge");
      steps(3, 0, 0, 1, 0, "to_right_edge");
    end
    check("col_right_edge", 32'(bus.col), 32'd6);

    steps(4, 1, 0, 1, 0, "fail");
    steps(1, 0, 0, 1, 1, "fail");
    steps(4, 1, 0, 1, 1, "fail");
    steps(4, 0, 0, 1, 1, "fail");
    steps(4, 0, 1, 1, 1, "fail");
    steps(4, 0, 0, 1, 1, "fail");
    check("col_frozen", 32'(bus.col), 32'd5);

    steps(4, 0, 0, 1, 0, "rst_lock");
    steps(5, 1, 0, 1, 0, "rst_lock");
    do_reset("reset_mid_lockout");
    steps(4, 0, 0, 1, 0, "after_rst");

    do_reset("reset_rand");
    for (int i = 0; i < 200; i++) begin
      logic bl, br, en;
      bl = ($urandom_range(0, 9) < 3) ? ~m_bl : m_bl;
      br = ($urandom_range(0, 9) < 2) ? ~m_br : m_br;
      en = ($urandom_range(0, 39) != 0);
      step(bl, br, en, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
